id_decode_ctrl: RTL
===================

// Module: id_decode_ctrl
// PURPOSE
//  Decode-stage sequencer between fetch and execute. Accepts instructions from IF over a
//  valid/ready handshake and buffers them (output register + 1-entry skid). Generates the
//  immediate through an id_immGen instance and registers it with the instruction.
//  Detects load-use hazards against EX and inserts bubbles; handles pipeline flush.
// PARAMETERS
//  XLEN           32  width of PC
//  BUBBLE_CYCLES  1   bubbles inserted per load-use hazard; legal range 1..3
// PORTS
//  i_clk           in   1     clock, rising edge
//  i_rst           in   1     asynchronous reset, active high
//  i_if_valid      in   1     IF presents an instruction
//  o_if_ready      out  1     ID can accept; registered
//  i_if_instr      in   32    instruction word from IF
//  i_if_pc         in   XLEN  PC of i_if_instr
//  o_ex_valid      out  1     ID output valid to EX
//  i_ex_ready      in   1     EX accepts this cycle
//  o_ex_instr      out  32    registered instruction
//  o_ex_pc         out  XLEN  registered PC
//  o_ex_imm        out  32    registered immediate (id_immGen of o_ex_instr)
//  i_ex_load_valid in   1     instruction currently in EX is a load
//  i_ex_load_rd    in   5     rd of that load
//  i_flush         in   1     synchronous flush (branch/jump redirect)
//  o_ex_illegal    out  1     unknown opcode flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, immediate): o_ex_valid=0, o_ex_instr=32'h0000_0013 (NOP), o_ex_pc=0,
//   o_ex_imm=0, o_ex_illegal=0, o_if_ready=1, skid empty, bubble counter=0, state EMPTY.
//  Handshakes: IF transfer = i_if_valid & o_if_ready; EX transfer = o_ex_valid & i_ex_ready.
//   o_ex_* held stable while o_ex_valid=1 and i_ex_ready=0.
//  States: EMPTY (out reg empty), FULL (o_ex_valid=1), STALL (out reg holds instr, valid=0).
//  Load into out reg: from skid if skid full, else from IF transfer; occurs when state
//   EMPTY, or FULL with EX transfer. Otherwise an IF transfer writes the skid.
//  o_if_ready(next) = skid empty after the cycle's updates.
//  Hazard check at load: hit = i_ex_load_valid & rd!=0 & ((uses_rs1 & rs1==rd) |
//   (uses_rs2 & rs2==rd)); rs1=[19:15], rs2=[24:20]. uses_rs1 = opcode not LUI/AUIPC/JAL;
//   uses_rs2 = opcode in {0110011 R, 0100011 STORE, 1100011 BRANCH}.
//   hit -> STALL, counter=BUBBLE_CYCLES; no hit -> FULL.
//  STALL: counter decrements every cycle regardless of i_ex_ready; on counter==1 -> FULL.
//  Latency: IF transfer in cycle N -> o_ex_valid in N+1 (no hazard) or N+1+BUBBLE_CYCLES.
//   Throughput 1 instr/cycle with i_ex_ready=1 and no hazards.
//  Load into EMPTY with no new source and FULL+EX transfer -> EMPTY.
//  i_flush: dominates all; next edge clears out reg (NOP, valid=0), skid, counter,
//   state EMPTY; same-cycle IF transfer discarded; o_if_ready=1 next cycle.
//  Imm rules: identical to id_immGen (I/S/B/U/J sign-extension, bit0 of B/J forced 0).
//  Skid full and out reg stalled: o_if_ready=0; no IF data lost or duplicated.
// CONFIGURATION
//  ID_ILLEGAL_TRAP_EN defined: o_ex_illegal registered with instr; 1 when opcode[1:0]!=2'b11
//   or opcode not in {LUI,AUIPC,JAL,JALR,BRANCH,LOAD,STORE,OP-IMM,OP,FENCE,SYSTEM}.
//   Illegal instructions skip hazard check (go FULL).
//  Not defined: o_ex_illegal tied 0; all else unchanged.
// TESTING
//  Reset: assert i_rst mid-stream with skid full -> outputs at reset values same cycle, o_if_ready=1.
//  Streaming: 4 ADDI (32'h00100093..) back-to-back, i_ex_ready=1 -> o_ex_valid 1 per cycle from N+1,
//   o_ex_imm=1, order preserved.
//  Backpressure: i_ex_ready=0 for 3 cycles while IF valid -> skid fills, o_if_ready=0,
//   o_ex_* stable; release -> both instrs delivered in order.
//  Load-use: EX load rd=x5, ID gets ADD x6,x5,x1 -> o_ex_valid=0 for BUBBLE_CYCLES cycles,
//   then valid; rd=x0 -> no bubble.
//  Flush: i_flush with out reg FULL, skid full, IF valid -> next cycle o_ex_valid=0,
//   o_ex_instr=32'h13, o_if_ready=1; flushed IF instr never appears.
//  Illegal (ID_ILLEGAL_TRAP_EN): instr 32'h0000_0000 -> o_ex_illegal=1; macro off -> 0.

Source files
------------

// File: rtl/id_decode_ctrl_if.sv
// IF->ID->EX bundle for the decode-stage sequencer.
// master drives the fetch/EX-side inputs; slave is the decode stage.
interface id_decode_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            i_if_valid;
    logic            o_if_ready;
    logic [31:0]     i_if_instr;
    logic [XLEN-1:0] i_if_pc;
    logic            o_ex_valid;
    logic            i_ex_ready;
    logic [31:0]     o_ex_instr;
    logic [XLEN-1:0] o_ex_pc;
    logic [31:0]     o_ex_imm;
    logic            i_ex_load_valid;
    logic [4:0]      i_ex_load_rd;
    logic            i_flush;
    logic            o_ex_illegal;

    modport master (
        output i_if_valid, i_if_instr, i_if_pc, i_ex_ready,
               i_ex_load_valid, i_ex_load_rd, i_flush,
        input  o_if_ready, o_ex_valid, o_ex_instr, o_ex_pc, o_ex_imm, o_ex_illegal
    );

    modport slave (
        input  i_if_valid, i_if_instr, i_if_pc, i_ex_ready,
               i_ex_load_valid, i_ex_load_rd, i_flush,
        output o_if_ready, o_ex_valid, o_ex_instr, o_ex_pc, o_ex_imm, o_ex_illegal
    );
endinterface

// File: rtl/id_decode_ctrl.sv
// Decode-stage sequencer: output register + 1-entry skid, immediate generation,
// load-use bubble insertion and flush. Define ID_ILLEGAL_TRAP_EN to flag unknown opcodes.
module id_immGen (
    input  logic [31:0] i_instr,
    output logic [31:0] o_imm
);
    always_comb begin
        o_imm = 32'h0;
        case (i_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111:
                o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            7'b0100011:
                o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            7'b1100011:
                o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                o_imm = {i_instr[31:12], 12'h000};
            7'b1101111:
                o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
            default: o_imm = 32'h0;
        endcase
    end
endmodule

module id_decode_ctrl #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned BUBBLE_CYCLES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    id_decode_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {EMPTY, FULL, STALL} state_e;

    state_e          state_q;
    logic            ex_valid_q;
    logic [31:0]     ex_instr_q;
    logic [XLEN-1:0] ex_pc_q;
    logic [31:0]     ex_imm_q;
    logic            ex_illegal_q;
    logic            skid_valid_q;
    logic [31:0]     skid_instr_q;
    logic [XLEN-1:0] skid_pc_q;
    logic [CNT_W-1:0] cnt_q;
    logic            if_ready_q;

    logic            if_xfer, ex_xfer, load, skid_wr, skid_valid_d;
    logic [31:0]     src_instr, src_imm;
    logic [XLEN-1:0] src_pc;
    logic [6:0]      src_op;
    logic            uses_rs1, uses_rs2, hazard, illegal_c;

    // Source for the output register: skid has priority over the live IF word.
    always_comb begin
        if_xfer      = bus.i_if_valid & if_ready_q;
        ex_xfer      = ex_valid_q & bus.i_ex_ready;
        src_instr    = skid_valid_q ? skid_instr_q : bus.i_if_instr;
        src_pc       = skid_valid_q ? skid_pc_q    : bus.i_if_pc;
        src_op       = src_instr[6:0];
        load         = ((state_q == EMPTY) | ex_xfer) & (skid_valid_q | if_xfer);
        skid_wr      = if_xfer & ~load;
        skid_valid_d = skid_valid_q ? ~load : skid_wr;
        uses_rs1     = ~((src_op == OP_LUI) | (src_op == OP_AUIPC) | (src_op == OP_JAL));
        uses_rs2     = (src_op == OP_OP) | (src_op == OP_STORE) | (src_op == OP_BRANCH);
`ifdef ID_ILLEGAL_TRAP_EN
        illegal_c    = (src_op[1:0] != 2'b11) |
                       ~(src_op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                                        OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM});
`else
        illegal_c    = 1'b0;
`endif
        hazard       = bus.i_ex_load_valid & (bus.i_ex_load_rd != 5'd0) & ~illegal_c &
                       ((uses_rs1 & (src_instr[19:15] == bus.i_ex_load_rd)) |
                        (uses_rs2 & (src_instr[24:20] == bus.i_ex_load_rd)));
    end

    id_immGen u_imm_gen (
        .i_instr (src_instr),
        .o_imm   (src_imm)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= EMPTY;
            ex_valid_q   <= 1'b0;
            ex_instr_q   <= NOP;
            ex_pc_q      <= '0;
            ex_imm_q     <= 32'h0;
            ex_illegal_q <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= '0;
            cnt_q        <= '0;
            if_ready_q   <= 1'b1;
        end else if (bus.i_flush) begin
            state_q      <= EMPTY;
            ex_valid_q   <= 1'b0;
            ex_instr_q   <= NOP;
            ex_pc_q      <= '0;
            ex_imm_q     <= 32'h0;
            ex_illegal_q <= 1'b0;
            skid_valid_q <= 1'b0;
            cnt_q        <= '0;
            if_ready_q   <= 1'b1;
        end else begin
            if (load) begin
                ex_instr_q   <= src_instr;
                ex_pc_q      <= src_pc;
                ex_imm_q     <= src_imm;
                ex_illegal_q <= illegal_c;
                state_q      <= hazard ? STALL : FULL;
                ex_valid_q   <= ~hazard;
                cnt_q        <= hazard ? CNT_W'(BUBBLE_CYCLES) : '0;
            end else begin
                case (state_q)
                    FULL: begin
                        if (bus.i_ex_ready) begin
                            state_q    <= EMPTY;
                            ex_valid_q <= 1'b0;
                        end
                    end
                    // Bubble countdown ignores EX backpressure.
                    STALL: begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q    <= FULL;
                            ex_valid_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (skid_wr) begin
                skid_instr_q <= bus.i_if_instr;
                skid_pc_q    <= bus.i_if_pc;
            end
            skid_valid_q <= skid_valid_d;
            if_ready_q   <= ~skid_valid_d;
        end
    end

    assign bus.o_if_ready   = if_ready_q;
    assign bus.o_ex_valid   = ex_valid_q;
    assign bus.o_ex_instr   = ex_instr_q;
    assign bus.o_ex_pc      = ex_pc_q;
    assign bus.o_ex_imm     = ex_imm_q;
    assign bus.o_ex_illegal = ex_illegal_q;
endmodule
